// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback arbiter.
package regfile_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] reg_data_t;

  // X31 is the hardwired zero register: writes to it are consumed but dropped.
  localparam reg_idx_t REG_ZERO = 5'd31;
  localparam int       NUM_REGS = 32;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-input round-robin grant logic holding the "last granted" priority bit.
// last_q = 1 means requester 1 was granted last, so requester 0 wins the
// next contention; it resets to 1 so requester 0 wins the first one.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic last_q;
  logic last_d;

  // Grant decision: nothing during reset or when disabled; otherwise the sole
  // valid requester, or the one not granted last time on contention.
  always_comb begin
    grant_o = 2'b00;
    if (!reset && enable_i) begin
      unique case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Priority bit moves only when a grant (and therefore a transfer) happens.
  always_comb begin
    last_d = last_q;
    if (grant_o[0]) begin
      last_d = 1'b0;
    end else if (grant_o[1]) begin
      last_d = 1'b1;
    end
  end

  // Priority bit register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port.
// Two writeback requesters (ALU, load) share one registered write per cycle.
// Optional read bypass is enabled by defining REGFILE_WRITE_ARB_BYPASS_EN.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData
`ifdef REGFILE_WRITE_ARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] RfData1,
  input  logic [DATA_W-1:0] RfData2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
`endif
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [1:0]        grant;
  logic              wen_q,   wen_d;
  logic [ADDR_W-1:0] wreg_q,  wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable_i (~hold),
    .valid_i  ({req1_valid, req0_valid}),
    .grant_o  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Output stage next state: capture the granted request; X31 is captured
  // but never enabled. With no transfer the enable drops and data holds.
  always_comb begin
    wen_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (grant[0]) begin
      wen_d   = (req0_reg != ZERO_IDX);
      wreg_d  = req0_reg;
      wdata_d = req0_data;
    end else if (grant[1]) begin
      wen_d   = (req1_reg != ZERO_IDX);
      wreg_d  = req1_reg;
      wdata_d = req1_data;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  // A write staged when reset arrives is discarded rather than committed.
  assign RegWrite      = wen_q & ~reset;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;

`ifdef REGFILE_WRITE_ARB_BYPASS_EN
  // Forward the in-flight write to matching reads; X31 never forwards since
  // its enable is always low.
  always_comb begin
    ReadData1 = RfData1;
    ReadData2 = RfData2;
    if (RegWrite && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
    if (RegWrite && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              hold = 1'b0;
  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_reg = '0;
  logic [DATA_W-1:0] req0_data = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_reg = '0;
  logic [DATA_W-1:0] req1_data = '0;
  logic              req1_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
`ifdef REGFILE_WRITE_ARB_BYPASS_EN
  logic [ADDR_W-1:0] ReadRegister1 = '0;
  logic [ADDR_W-1:0] ReadRegister2 = '0;
  logic [DATA_W-1:0] RfData1 = '0;
  logic [DATA_W-1:0] RfData2 = '0;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Register file fed by the DUT's write port.
  logic              rf_clr = 1'b1;
  logic [DATA_W-1:0] rf_dut [32];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .hold          (hold),
    .req0_valid    (req0_valid),
    .req0_reg      (req0_reg),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_reg      (req1_reg),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData)
`ifdef REGFILE_WRITE_ARB_BYPASS_EN
    ,
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .RfData1       (RfData1),
    .RfData2       (RfData2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
`endif
  );

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf_dut[i] <= '0;
    end else if (RegWrite) begin
      rf_dut[WriteRegister] <= WriteData;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rf_clr = 1'b1;
    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 64'h1;
    req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 64'h2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total += 5;
      if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rdy0 got=%b want=0", req0_ready); end
      if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rdy1 got=%b want=0", req1_ready); end
      if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b want=0", RegWrite); end
      if (WriteRegister !== '0) begin n_bad++; $display("FAIL reset_wreg got=%0d want=0", WriteRegister); end
      if (WriteData !== '0) begin n_bad++; $display("FAIL reset_wdata got=%h want=0", WriteData); end
      tick();
    end
    rf_clr = 1'b0;
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 64'hA0;
    @(negedge clk);
    n_total += 2;
    if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL single_rdy got=%b want=1", req0_ready); end
    if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL single_we_pre got=%b want=0", RegWrite); end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_total += 3;
    if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL single_we got=%b want=1", RegWrite); end
    if (WriteRegister !== 5'd5) begin n_bad++; $display("FAIL single_wreg got=%0d want=5", WriteRegister); end
    if (WriteData !== 64'hA0) begin n_bad++; $display("FAIL single_wdata got=%h want=a0", WriteData); end
    tick();
    @(negedge clk);
    n_total += 3;
    if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL single_we_post got=%b want=0", RegWrite); end
    if (WriteData !== 64'hA0) begin n_bad++; $display("FAIL single_hold_data got=%h want=a0", WriteData); end
    if (rf_dut[5] !== 64'hA0) begin n_bad++; $display("FAIL single_rf5 got=%h want=a0", rf_dut[5]); end
  endtask

  task automatic test_contention();
    logic [DATA_W-1:0] prev;
    do_reset();
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 64'h11;
    req1_valid = 1'b1; req1_reg = 5'd3; req1_data = 64'h22;
    prev = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_total += 2;
      if (req0_ready !== (k % 2 == 0)) begin n_bad++; $display("FAIL cont_rdy0 k=%0d got=%b want=%b", k, req0_ready, (k % 2 == 0)); end
      if (req1_ready !== (k % 2 == 1)) begin n_bad++; $display("FAIL cont_rdy1 k=%0d got=%b want=%b", k, req1_ready, (k % 2 == 1)); end
      if (k > 0) begin
        n_total += 2;
        if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL cont_we k=%0d got=%b want=1", k, RegWrite); end
        if (WriteData !== prev) begin n_bad++; $display("FAIL cont_wdata k=%0d got=%h want=%h", k, WriteData, prev); end
      end
      prev = (k % 2 == 0) ? 64'h11 : 64'h22;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    @(negedge clk);
    n_total += 2;
    if (rf_dut[3] !== 64'h22) begin n_bad++; $display("FAIL cont_rf3 got=%h want=22", rf_dut[3]); end
    if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL cont_we_end got=%b want=0", RegWrite); end
  endtask

  task automatic test_x31();
    do_reset();
    req1_valid = 1'b1; req1_reg = 5'd31; req1_data = 64'hA0;
    @(negedge clk);
    n_total += 1;
    if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL x31_rdy got=%b want=1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    n_total += 1;
    if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL x31_we got=%b want=0", RegWrite); end
    tick();
    @(negedge clk);
    n_total += 1;
    if (rf_dut[31] !== '0) begin n_bad++; $display("FAIL x31_rf got=%h want=0", rf_dut[31]); end
  endtask

  task automatic test_hold();
    do_reset();
    req0_valid = 1'b1; req0_reg = 5'd9;  req0_data = 64'h55;
    req1_valid = 1'b1; req1_reg = 5'd10; req1_data = 64'h66;
    @(negedge clk);
    n_total += 2;
    if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL hold_rdy0 got=%b want=1", req0_ready); end
    if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL hold_rdy1_pre got=%b want=0", req1_ready); end
    tick();
    req0_valid = 1'b0; hold = 1'b1;
    @(negedge clk);
    n_total += 3;
    if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL hold_commit_we got=%b want=1", RegWrite); end
    if (WriteRegister !== 5'd9) begin n_bad++; $display("FAIL hold_commit_reg got=%0d want=9", WriteRegister); end
    if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL hold_rdy1_a got=%b want=0", req1_ready); end
    tick();
    @(negedge clk);
    n_total += 3;
    if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL hold_rdy1_b got=%b want=0", req1_ready); end
    if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL hold_we_idle got=%b want=0", RegWrite); end
    if (rf_dut[9] !== 64'h55) begin n_bad++; $display("FAIL hold_rf9 got=%h want=55", rf_dut[9]); end
    tick();
    hold = 1'b0;
    @(negedge clk);
    n_total += 1;
    if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL hold_rdy1_release got=%b want=1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    n_total += 3;
    if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL hold_r1_we got=%b want=1", RegWrite); end
    if (WriteRegister !== 5'd10) begin n_bad++; $display("FAIL hold_r1_reg got=%0d want=10", WriteRegister); end
    if (WriteData !== 64'h66) begin n_bad++; $display("FAIL hold_r1_data got=%h want=66", WriteData); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    req0_valid = 1'b1; req0_reg = 5'd12; req0_data = 64'h77;
    @(negedge clk);
    tick();
    req0_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_total += 1;
    if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL midrst_we got=%b want=0", RegWrite); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_total += 2;
    if (rf_dut[12] === 64'h77) begin n_bad++; $display("FAIL midrst_rf12 got=%h want=not 77", rf_dut[12]); end
    if (WriteRegister !== '0) begin n_bad++; $display("FAIL midrst_wreg got=%0d want=0", WriteRegister); end
  endtask

  // Randomized run against a transaction-level model: a request is pending
  // until transferred; grants follow the round-robin rule; each transfer
  // becomes a staged write that lands in the register file one edge later.
  task automatic test_random();
    logic [DATA_W-1:0] rf_ref [32];
    bit pend0, pend1, g0, g1, rst_now, idle;
    int m_last;
    bit m_we;
    logic [ADDR_W-1:0] m_reg;
    logic [DATA_W-1:0] m_data;
    rf_clr = 1'b1;
    do_reset();
    rf_clr = 1'b0;
    for (int i = 0; i < 32; i++) rf_ref[i] = '0;
    pend0 = 1'b0; pend1 = 1'b0;
    m_last = 1; m_we = 1'b0; m_reg = '0; m_data = '0;
    for (int c = 0; c < 600; c++) begin
      idle = (c >= 596);
      rst_now = !idle && ($urandom_range(0, 24) == 0);
      reset = rst_now;
      hold = !idle && ($urandom_range(0, 4) == 0);
      if (!pend0 && $urandom_range(0, 2) != 0) begin
        pend0 = 1'b1;
        req0_reg = ($urandom_range(0, 7) == 0) ? 5'd31 : ADDR_W'($urandom_range(0, 31));
        req0_data = {$urandom, $urandom};
      end
      if (!pend1 && $urandom_range(0, 2) != 0) begin
        pend1 = 1'b1;
        req1_reg = ($urandom_range(0, 7) == 0) ? 5'd31 : ADDR_W'($urandom_range(0, 31));
        req1_data = {$urandom, $urandom};
      end
      req0_valid = pend0 && !idle;
      req1_valid = pend1 && !idle;
      g0 = !rst_now && !hold && req0_valid && (!req1_valid || m_last == 1);
      g1 = !rst_now && !hold && req1_valid && (!req0_valid || m_last == 0);
      @(negedge clk);
      n_total += 5;
      if (req0_ready !== g0) begin n_bad++; $display("FAIL rnd_rdy0 c=%0d got=%b want=%b", c, req0_ready, g0); end
      if (req1_ready !== g1) begin n_bad++; $display("FAIL rnd_rdy1 c=%0d got=%b want=%b", c, req1_ready, g1); end
      if (RegWrite !== (m_we && !rst_now)) begin n_bad++; $display("FAIL rnd_we c=%0d got=%b want=%b", c, RegWrite, m_we && !rst_now); end
      if (WriteRegister !== m_reg) begin n_bad++; $display("FAIL rnd_wreg c=%0d got=%0d want=%0d", c, WriteRegister, m_reg); end
      if (WriteData !== m_data) begin n_bad++; $display("FAIL rnd_wdata c=%0d got=%h want=%h", c, WriteData, m_data); end
      if (m_we && !rst_now) rf_ref[m_reg] = m_data;
      if (rst_now) begin
        m_last = 1; m_we = 1'b0; m_reg = '0; m_data = '0;
      end else if (g0) begin
        m_we = (req0_reg != 5'd31); m_reg = req0_reg; m_data = req0_data;
        m_last = 0; pend0 = 1'b0;
      end else if (g1) begin
        m_we = (req1_reg != 5'd31); m_reg = req1_reg; m_data = req1_data;
        m_last = 1; pend1 = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      tick();
    end
    reset = 1'b0; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    for (int r = 0; r < 32; r++) begin
      n_total++;
      if (rf_dut[r] !== rf_ref[r]) begin n_bad++; $display("FAIL rnd_rf x%0d got=%h want=%h", r, rf_dut[r], rf_ref[r]); end
    end
  endtask

`ifdef REGFILE_WRITE_ARB_BYPASS_EN
  task automatic test_bypass();
    logic [DATA_W-1:0] rnd;
    do_reset();
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 64'h1234;
    tick();
    req0_valid = 1'b0;
    rnd = {$urandom, $urandom};
    ReadRegister1 = 5'd7; RfData1 = '0;
    ReadRegister2 = 5'd8; RfData2 = rnd;
    #1;
    n_total += 2;
    if (ReadData1 !== 64'h1234) begin n_bad++; $display("FAIL byp_rd1 got=%h want=1234", ReadData1); end
    if (ReadData2 !== rnd) begin n_bad++; $display("FAIL byp_rd2 got=%h want=%h", ReadData2, rnd); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x31();
    test_hold();
    test_reset_midop();
`ifdef REGFILE_WRITE_ARB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
